doa_lag_tracker: RTL and testbench

//  Downstream stage of the mic subsystem. Sequences repeated measurements by pulsing subsys_start.

---
 rtl/doa_lag_tracker.sv | 186 ++++++++++++++++++
 tb/tb_doa_lag_tracker.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/doa_lag_tracker.sv
// DOA lag tracker: sequences mic-subsystem measurements and averages lag_diff over a 2**AVG_LOG2 window.
// Optional outlier rejection is built when DOA_OUTLIER_REJECT_EN is defined.
module doa_lag_tracker #(
  parameter int LAGNUM      = 10,
  parameter int AVG_LOG2    = 3,
  parameter int GAP_CYC     = 1024,
  parameter int TIMEOUT_CYC = 2**20,
  parameter int MAX_JUMP    = 3,
  parameter int REJ_LIMIT   = 4
) (
  input  logic              clk_60MHz,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              win_clr,
  input  logic              subsys_done,
  input  logic signed [5:0] lag_diff,
  output logic              subsys_start,
  output logic signed [5:0] avg_lag,
  output logic              avg_upd,
  output logic              avg_valid,
  output logic              timeout_err
);

  localparam int unsigned LAG_W     = 6;
  localparam int unsigned AVG_DEPTH = 1 << AVG_LOG2;
  localparam int unsigned SUM_W     = LAG_W + AVG_LOG2;
  localparam int unsigned FILL_W    = AVG_LOG2 + 1;
  localparam int unsigned PTR_W     = AVG_LOG2;
  localparam int unsigned TMR_MAX   = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
  localparam int unsigned TMR_W     = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;

  localparam logic signed [LAG_W-1:0] LAG_LO = LAG_W'(-LAGNUM);
  localparam logic signed [LAG_W-1:0] LAG_HI = LAG_W'(LAGNUM - 1);

  if (AVG_LOG2 < 1 || AVG_LOG2 > 5 || GAP_CYC < 1 || TIMEOUT_CYC < 2 ||
      LAGNUM < 1 || LAGNUM > 32 || MAX_JUMP < 0 || REJ_LIMIT < 1) begin : g_param_check
    $error("doa_lag_tracker: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_ACCUM = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [TMR_W-1:0]          r_timer;
  logic                      w_timeout_hit;
  logic                      r_subsys_start;

  logic signed [LAG_W-1:0]   r_lag;
  logic signed [LAG_W-1:0]   r_buf [AVG_DEPTH];
  logic signed [SUM_W-1:0]   r_sum;
  logic [FILL_W-1:0]         r_fill;
  logic [PTR_W-1:0]          r_wr_ptr;
  logic signed [LAG_W-1:0]   r_avg_lag;
  logic                      r_avg_upd;
  logic                      r_avg_valid;
  logic                      r_timeout_err;

  logic                      w_in_range;
  logic                      w_reject;
  logic                      w_accept;
  logic signed [SUM_W-1:0]   w_sum_nxt;
  logic [FILL_W-1:0]         w_fill_nxt;
  logic                      w_full_nxt;

  // Measurement sequencer: next-state and timeout decode
  always_comb begin
    w_state_nxt   = r_state;
    w_timeout_hit = 1'b0;
    case (r_state)
      S_IDLE:  if (enable) w_state_nxt = S_START;
      S_START: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (subsys_done) begin
          w_state_nxt = S_ACCUM;
        end else if (r_timer == TMR_W'(TIMEOUT_CYC - 1)) begin
          w_state_nxt   = S_GAP;
          w_timeout_hit = 1'b1;
        end
      end
      S_ACCUM: w_state_nxt = S_GAP;
      S_GAP: begin
        if (r_timer == TMR_W'(GAP_CYC - 1)) w_state_nxt = enable ? S_START : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; timer restarts on every state change
  always_ff @(posedge clk_60MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_timer        <= '0;
      r_subsys_start <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_timer        <= (w_state_nxt != r_state) ? '0 : r_timer + 1'b1;
      r_subsys_start <= (w_state_nxt == S_START);
    end
  end

  assign w_in_range = (r_lag >= LAG_LO) && (r_lag <= LAG_HI);
  assign w_accept   = (r_state == S_ACCUM) && !win_clr && w_in_range && !w_reject;
  assign w_sum_nxt  = r_sum + SUM_W'(r_lag) - SUM_W'(r_buf[r_wr_ptr]);
  assign w_fill_nxt = (r_fill == FILL_W'(AVG_DEPTH)) ? r_fill : r_fill + 1'b1;
  assign w_full_nxt = (w_fill_nxt == FILL_W'(AVG_DEPTH));

`ifdef DOA_OUTLIER_REJECT_EN
  localparam int unsigned REJ_W = (REJ_LIMIT > 1) ? $clog2(REJ_LIMIT) : 1;

  logic [REJ_W-1:0]    r_rej_cnt;
  logic signed [6:0]   w_diff;
  logic [6:0]          w_abs_diff;
  logic                w_far;

  assign w_diff     = 7'(r_lag) - 7'(r_avg_lag);
  assign w_abs_diff = w_diff[6] ? 7'(-w_diff) : 7'(w_diff);
  assign w_far      = r_avg_valid && (w_abs_diff > 7'(MAX_JUMP));
  // The REJ_LIMIT-th consecutive outlier is let through so a real move is eventually tracked
  assign w_reject   = w_far && (r_rej_cnt != REJ_W'(REJ_LIMIT - 1));

  always_ff @(posedge clk_60MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_rej_cnt <= '0;
    end else if (win_clr) begin
      r_rej_cnt <= '0;
    end else if (r_state == S_ACCUM && w_in_range) begin
      r_rej_cnt <= w_reject ? r_rej_cnt + 1'b1 : '0;
    end
  end
`else
  assign w_reject = 1'b0;
`endif

  // Sample capture, circular window, running sum and published average
  always_ff @(posedge clk_60MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_lag         <= '0;
      for (int i = 0; i < int'(AVG_DEPTH); i++) r_buf[i] <= '0;
      r_sum         <= '0;
      r_fill        <= '0;
      r_wr_ptr      <= '0;
      r_avg_lag     <= '0;
      r_avg_upd     <= 1'b0;
      r_avg_valid   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_avg_upd <= 1'b0;
      if (r_state == S_WAIT && subsys_done) r_lag <= lag_diff;
      if (win_clr) begin
        for (int i = 0; i < int'(AVG_DEPTH); i++) r_buf[i] <= '0;
        r_sum         <= '0;
        r_fill        <= '0;
        r_wr_ptr      <= '0;
        r_avg_lag     <= '0;
        r_avg_valid   <= 1'b0;
        r_timeout_err <= 1'b0;
      end else begin
        if (w_timeout_hit) r_timeout_err <= 1'b1;
        if (w_accept) begin
          r_buf[r_wr_ptr] <= r_lag;
          r_sum           <= w_sum_nxt;
          r_wr_ptr        <= r_wr_ptr + 1'b1;
          r_fill          <= w_fill_nxt;
          if (w_full_nxt) begin
            r_avg_lag   <= LAG_W'(w_sum_nxt >>> AVG_LOG2);
            r_avg_upd   <= 1'b1;
            r_avg_valid <= 1'b1;
          end
        end
      end
    end
  end

  assign subsys_start = r_subsys_start;
  assign avg_lag      = r_avg_lag;
  assign avg_upd      = r_avg_upd;
  assign avg_valid    = r_avg_valid;
  assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_doa_lag_tracker.sv
// Scoreboard bench for doa_lag_tracker: a mic-subsystem stub answers each start pulse with directed lags;
// expected averages are queued at issue time and checked by an independent monitor on avg_upd.
module tb_doa_lag_tracker;

  localparam int GAP = 4;
  localparam int TMO = 20;

  logic              clk_60MHz = 1'b0;
  logic              rst_n     = 1'b0;
  logic              enable    = 1'b0;
  logic              win_clr   = 1'b0;
  logic              subsys_done = 1'b0;
  logic signed [5:0] lag_diff  = '0;
  logic              subsys_start;
  logic signed [5:0] avg_lag;
  logic              avg_upd;
  logic              avg_valid;
  logic              timeout_err;

  doa_lag_tracker #(
    .LAGNUM(10), .AVG_LOG2(3), .GAP_CYC(GAP), .TIMEOUT_CYC(TMO), .MAX_JUMP(3), .REJ_LIMIT(4)
  ) dut (
    .clk_60MHz   (clk_60MHz),
    .rst_n       (rst_n),
    .enable      (enable),
    .win_clr     (win_clr),
    .subsys_done (subsys_done),
    .lag_diff    (lag_diff),
    .subsys_start(subsys_start),
    .avg_lag     (avg_lag),
    .avg_upd     (avg_upd),
    .avg_valid   (avg_valid),
    .timeout_err (timeout_err)
  );

  always #5 clk_60MHz = ~clk_60MHz;

  int cyc = 0;
  always @(posedge clk_60MHz) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;
  int exp_avg_q[$];
  int exp_cyc_q[$];
  int start_t[$];
  bit prev_start = 1'b0;
  int mon_avg;
  int mon_cyc;

  // Hand-computed vectors: 8x(+4), 8x(-3), +5, then range boundaries -10, +9, +10, -11
  int lag_a [21] = '{4, 4, 4, 4, 4, 4, 4, 4, -3, -3, -3, -3, -3, -3, -3, -3, 5, -10, 9, 10, -11};
  // 8x0 then four +6 against a zero average
  int lag_b [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 6, 6, 6, 6};
`ifdef DOA_OUTLIER_REJECT_EN
  int upd_a [21] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0};
  int avg_a [21] = '{0, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 3, 0, 0, 0, 2, 2, 0, 0, 0, 0};
  int upd_b [12] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1};
  int avg_b [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`else
  int upd_a [21] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
  int avg_a [21] = '{0, 0, 0, 0, 0, 0, 0, 4, 3, 2, 1, 0, -1, -2, -3, -3, -2, -3, -2, 0, 0};
  int upd_b [12] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
  int avg_b [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3};
`endif

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_start();
    int n = 0;
    do begin
      @(negedge clk_60MHz);
      n++;
    end while (!subsys_start && n < 200);
    if (!subsys_start) begin
      n_chk++;
      n_err++;
      $display("FAIL start_wait: no subsys_start within 200 cycles (cycle %0d)", cyc);
    end
  endtask

  // Mic stub: answer the next start after wt cycles; optionally pulse win_clr in the ACCUM cycle
  task automatic meas(input int lag, input int wt, input int exp_upd, input int exp_avg, input bit clr);
    wait_start();
    repeat (wt) @(negedge clk_60MHz);
    subsys_done = 1'b1;
    lag_diff    = 6'(lag);
    if (exp_upd != 0) begin
      exp_avg_q.push_back(exp_avg);
      exp_cyc_q.push_back(cyc + 2);
    end
    @(negedge clk_60MHz);
    subsys_done = 1'b0;
    win_clr     = clr;
    @(negedge clk_60MHz);
    win_clr     = 1'b0;
  endtask

  // Monitor: pop and compare on every avg_upd; also log start pulses
  always @(negedge clk_60MHz) begin
    if (avg_upd) begin
      if (exp_avg_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_upd: avg_lag %0d with no update expected (cycle %0d)", avg_lag, cyc);
      end else begin
        mon_avg = exp_avg_q.pop_front();
        mon_cyc = exp_cyc_q.pop_front();
        check("avg_lag", int'(avg_lag), mon_avg);
        check("avg_valid_at_upd", int'(avg_valid), 1);
        check("upd_latency_cycle", cyc, mon_cyc);
      end
    end
    if (subsys_start) begin
      start_t.push_back(cyc);
      check("start_pulse_width", int'(prev_start), 0);
    end
    prev_start = subsys_start;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int en_t;
    int s;
    int n;
    int n0;

    repeat (3) @(negedge clk_60MHz);
    check("rst_subsys_start", int'(subsys_start), 0);
    check("rst_avg_lag", int'(avg_lag), 0);
    check("rst_avg_upd", int'(avg_upd), 0);
    check("rst_avg_valid", int'(avg_valid), 0);
    check("rst_timeout_err", int'(timeout_err), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_60MHz);
    check("idle_no_start", start_t.size(), 0);

    enable = 1'b1;
    en_t   = cyc;
    for (int i = 0; i < 21; i++) begin
      meas(lag_a[i], (i % 3) + 1, upd_a[i], avg_a[i], 1'b0);
      if (i == 0) check("first_start_delay", (start_t.size() > 0) ? start_t[0] - en_t : -1, 1);
      if (i == 2) begin
        check("period_wait1", start_t[1] - start_t[0], 7);
        check("period_wait2", start_t[2] - start_t[1], 8);
      end
      if (i == 6) begin
        check("valid_before_full", int'(avg_valid), 0);
        check("avg_before_full", int'(avg_lag), 0);
      end
    end

    meas(1, 1, 0, 0, 1'b1);
    check("clr_accum_valid", int'(avg_valid), 0);
    check("clr_accum_avg", int'(avg_lag), 0);

    for (int i = 0; i < 12; i++) meas(lag_b[i], (i % 2) + 1, upd_b[i], avg_b[i], 1'b0);

    // Timeout: leave the start unanswered
    wait_start();
    s = cyc;
    n = 0;
    while (!timeout_err && n < 60) begin
      @(negedge clk_60MHz);
      n++;
    end
    check("timeout_err_set", int'(timeout_err), 1);
    check("timeout_delay", cyc - s, TMO + 1);
    subsys_done = 1'b1;
    lag_diff    = 6'(2);
    @(negedge clk_60MHz);
    subsys_done = 1'b0;
    wait_start();
    check("restart_after_timeout", cyc - s, TMO + GAP + 1);
    check("timeout_sticky", int'(timeout_err), 1);
    win_clr = 1'b1;
    @(negedge clk_60MHz);
    win_clr = 1'b0;
    check("timeout_cleared", int'(timeout_err), 0);
    check("clr_valid", int'(avg_valid), 0);
    subsys_done = 1'b1;
    lag_diff    = 6'(1);
    @(negedge clk_60MHz);
    subsys_done = 1'b0;
    repeat (3) @(negedge clk_60MHz);

    // Reset mid-operation, then stay idle until enable returns
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    check("midrst_subsys_start", int'(subsys_start), 0);
    check("midrst_avg_lag", int'(avg_lag), 0);
    check("midrst_timeout_err", int'(timeout_err), 0);
    @(negedge clk_60MHz);
    rst_n = 1'b1;
    n0 = start_t.size();
    repeat (20) @(negedge clk_60MHz);
    check("no_start_after_reset", start_t.size(), n0);
    enable = 1'b1;
    @(negedge clk_60MHz);
    check("start_after_reset", int'(subsys_start), 1);
    @(negedge clk_60MHz);

    check("scoreboard_drained", exp_avg_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
